// File: rtl/fsmd_updown_counter_param_if.sv
// fsmd_updown_counter_param_if
//   Bundles the control inputs and registered outputs of the parametrised
//   up/down counter. clk and rst are plain ports on the counter itself.
//
//   Handshake: there is no valid/ready pair. Every rising clk edge is one
//   transaction. The inputs (en, up, load, load_val, step, limit, sat_mode)
//   are sampled on that edge. The outputs (count, tc, state) are registered
//   and reflect that transaction from just after the same edge until the next one.
//
//   master modport: the block that drives the controls (testbench / datapath).
//   slave  modport: the counter.
interface fsmd_updown_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              up;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              sat_mode;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic [2:0]        state;

  modport master (
    output en, up, load, load_val, step, limit, sat_mode,
    input  count, tc, state
  );

  modport slave (
    input  en, up, load, load_val, step, limit, sat_mode,
    output count, tc, state
  );
endinterface

// File: rtl/fsmd_updown_counter_param.sv
// fsmd_updown_counter_param
//   Parametrised FSMD up/down counter with programmable step, inclusive upper
//   limit, synchronous load, enable, and wrap or saturate boundary handling.
//   tc is a registered one-cycle terminal-count pulse. state exposes the FSM.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave modport of fsmd_updown_counter_param_if
//          inputs  en, up, load, load_val, step, limit, sat_mode
//          outputs count, tc, state (all registered)
module fsmd_updown_counter_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic clk,
  input  logic rst,
  fsmd_updown_counter_param_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP     = 3'd1,
    DOWN   = 3'd2,
    SAT_HI = 3'd3,
    SAT_LO = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   sum;
  logic             in_sat;

  assign step_ext = WIDTH'(bus.step);
  // One extra bit so that an up step past the top of the range is still
  // visible as "greater than limit" instead of wrapping silently.
  assign sum    = {1'b0, count_q} + {1'b0, step_ext};
  assign in_sat = (state_q == SAT_HI) || (state_q == SAT_LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;

    if (bus.load) begin
      // Clamp the loaded value into the legal range 0..limit.
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      state_d = IDLE;
    end else if (!bus.en) begin
      if (!in_sat) state_d = IDLE;
    end else if (count_q > bus.limit) begin
      // The limit was lowered under the count: pull it back in range and
      // skip this cycle's step.
      count_d = bus.limit;
      state_d = bus.up ? UP : DOWN;
    end else if (bus.step == '0) begin
      if (!in_sat) state_d = bus.up ? UP : DOWN;
    end else if (bus.up) begin
      if (sum <= {1'b0, bus.limit}) begin
        count_d = sum[WIDTH-1:0];
        state_d = UP;
      end else if (!bus.sat_mode) begin
        count_d = '0;
        state_d = UP;
        tc_d    = 1'b1;
      end else begin
        count_d = bus.limit;
        state_d = SAT_HI;
        // Pulse only on entry; staying pinned at the top is silent.
        tc_d    = (state_q != SAT_HI);
      end
    end else begin
      if (step_ext <= count_q) begin
        count_d = count_q - step_ext;
        state_d = DOWN;
      end else if (!bus.sat_mode) begin
        count_d = bus.limit;
        state_d = DOWN;
        tc_d    = 1'b1;
      end else begin
        count_d = '0;
        state_d = SAT_LO;
        tc_d    = (state_q != SAT_LO);
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_fsmd_updown_counter_param.sv
module tb_fsmd_updown_counter_param;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;
  localparam int W      = WIDTH + 4;   // {count, tc, state}

  logic clk;
  logic rst;

  fsmd_updown_counter_param_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  fsmd_updown_counter_param #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  string cur_name = "init";
  string name_q[$];

  // Monitor: every edge presents a new output word; compare it with the
  // oldest expectation pushed by the driver.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = {bus.count, bus.tc, bus.state};
      n_checks++;
      if (g !== e) begin
        n_fails++;
        $display("FAIL %s: got count=%0d tc=%0b state=%0d, expected count=%0d tc=%0b state=%0d",
                 nm, g[W-1:4], g[3], g[2:0], e[W-1:4], e[3], e[2:0]);
      end
    end
  end

  // ---------------- driver ----------------
  logic [7:0]        c_limit;
  logic              c_sat;
  logic [STEP_W-1:0] c_step;

  task automatic drive(input string nm, input logic r, input logic e, input logic u,
                       input logic ld, input logic [WIDTH-1:0] lv,
                       input logic [WIDTH-1:0] ec, input logic et, input logic [2:0] es);
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.up       = u;
    bus.load     = ld;
    bus.load_val = lv;
    bus.step     = c_step;
    bus.limit    = c_limit;
    bus.sat_mode = c_sat;
    exp_q.push_back({ec, et, es});
    name_q.push_back(nm);
  endtask

  task automatic step_cnt(input string nm, input logic u,
                          input logic [WIDTH-1:0] ec, input logic et, input logic [2:0] es);
    drive(nm, 1'b0, 1'b1, u, 1'b0, 8'd0, ec, et, es);
  endtask

  task automatic do_load(input string nm, input logic [WIDTH-1:0] lv,
                         input logic [WIDTH-1:0] ec);
    drive(nm, 1'b0, 1'b1, 1'b1, 1'b1, lv, ec, 1'b0, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.step = '0; bus.limit = '0; bus.sat_mode = 1'b0;
    c_limit = 8'd9; c_sat = 1'b0; c_step = 4'd1;

    // Reset held with en/up active.
    drive("reset0", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 3'd0);
    drive("reset1", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 3'd0);

    // Count up 1..9 then wrap to 0 with tc.
    for (int i = 1; i <= 9; i++)
      step_cnt("up_count", 1'b1, WIDTH'(i), 1'b0, 3'd1);
    step_cnt("up_wrap", 1'b1, 8'd0, 1'b1, 3'd1);

    // Down wrap: 2 - 3 -> limit.
    do_load("load2", 8'd2, 8'd2);
    c_step = 4'd3;
    step_cnt("down_wrap", 1'b0, 8'd9, 1'b1, 3'd2);
    drive("en0_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd9, 1'b0, 3'd0);

    // Saturate high.
    c_limit = 8'd200; c_sat = 1'b1; c_step = 4'd7;
    do_load("load190", 8'd190, 8'd190);
    step_cnt("sat_hi_step", 1'b1, 8'd197, 1'b0, 3'd1);
    step_cnt("sat_hi_entry", 1'b1, 8'd200, 1'b1, 3'd3);
    step_cnt("sat_hi_hold1", 1'b1, 8'd200, 1'b0, 3'd3);
    step_cnt("sat_hi_hold2", 1'b1, 8'd200, 1'b0, 3'd3);
    step_cnt("sat_hi_exit", 1'b0, 8'd193, 1'b0, 3'd2);

    // Saturate low.
    c_step = 4'd4;
    do_load("load5", 8'd5, 8'd5);
    step_cnt("sat_lo_step", 1'b0, 8'd1, 1'b0, 3'd2);
    step_cnt("sat_lo_entry", 1'b0, 8'd0, 1'b1, 3'd4);
    step_cnt("sat_lo_hold", 1'b0, 8'd0, 1'b0, 3'd4);
    drive("sat_lo_en0", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 3'd4);
    step_cnt("sat_lo_exit", 1'b1, 8'd4, 1'b0, 3'd1);

    // Exact landings are not boundary events.
    do_load("load4", 8'd4, 8'd4);
    step_cnt("exact_zero", 1'b0, 8'd0, 1'b0, 3'd2);
    do_load("load196", 8'd196, 8'd196);
    step_cnt("exact_limit", 1'b1, 8'd200, 1'b0, 3'd1);

    // Load clamp and priority.
    c_limit = 8'd100;
    do_load("load_clamp", 8'd250, 8'd100);
    drive("rst_over_load", 1'b1, 1'b1, 1'b1, 1'b1, 8'd77, 8'd0, 1'b0, 3'd0);

    // Limit lowered under the count.
    c_sat = 1'b0; c_step = 4'd1;
    do_load("load50", 8'd50, 8'd50);
    c_limit = 8'd20;
    step_cnt("fixup", 1'b1, 8'd20, 1'b0, 3'd1);
    step_cnt("fixup_wrap", 1'b1, 8'd0, 1'b1, 3'd1);

    // step = 0 holds the count, follows direction.
    c_step = 4'd0;
    step_cnt("step0", 1'b0, 8'd0, 1'b0, 3'd2);

    // limit = 0: wrap pulses every cycle, saturate pulses once.
    c_limit = 8'd0; c_step = 4'd1;
    do_load("load_lim0", 8'd0, 8'd0);
    step_cnt("lim0_wrap1", 1'b1, 8'd0, 1'b1, 3'd1);
    step_cnt("lim0_wrap2", 1'b1, 8'd0, 1'b1, 3'd1);
    c_sat = 1'b1;
    step_cnt("lim0_sat1", 1'b1, 8'd0, 1'b1, 3'd3);
    step_cnt("lim0_sat2", 1'b1, 8'd0, 1'b0, 3'd3);

    // Reset mid-count.
    c_limit = 8'd100; c_sat = 1'b0; c_step = 4'd2;
    do_load("load30", 8'd30, 8'd30);
    step_cnt("count32", 1'b1, 8'd32, 1'b0, 3'd1);
    drive("rst_mid", 1'b1, 1'b1, 1'b1, 1'b1, 8'd9, 8'd0, 1'b0, 3'd0);

    // Drain the scoreboard with a bounded wait.
    drive("tail", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 3'd0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fsmd_updown_counter_param.md
Name: fsmd_updown_counter_param

Overview:
Parametrised FSMD up/down counter. Extends the fixed 4-bit up/down counter with configurable width, programmable step and upper limit, synchronous load, enable, and wrap or saturate boundary modes. A terminal-count pulse and explicit FSM state are exposed. Used as a general event/timer counter in datapath designs.

Parameters:
WIDTH, 8, counter and limit width in bits (>=2)
STEP_W, 4, step input width in bits (1..WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  count enable; one step per enabled cycle
up  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value loaded when load=1
step  input  STEP_W  increment/decrement amount; 0 = hold count
limit  input  WIDTH  inclusive upper bound; legal range is 0..limit
sat_mode  input  1  0 = wrap at boundaries, 1 = saturate
count  output  WIDTH  registered counter value
tc  output  1  registered one-cycle terminal-count pulse
state  output  3  registered FSM state

Behaviour:
- Reset and load are synchronous and active-high. All outputs are registered. There is no combinational input-to-output path.
- Reset (rst=1 at a clk edge): count=0, tc=0, state=IDLE.
- State encoding: IDLE=0, UP=1, DOWN=2, SAT_HI=3, SAT_LO=4.
- Priority per edge: rst > load > en.
- Load cycle:
  - count = min(load_val, limit); state = IDLE; tc = 0.
  - en and up are ignored in that cycle.
- en=0 (no rst or load): count holds and tc=0.
  - SAT_HI and SAT_LO hold.
  - Any other state goes to IDLE.
- Out-of-range fix-up: if en=1 and count > limit (limit was lowered), then count = limit and tc=0.
  - state = UP if up=1, else DOWN.
  - The step is not applied that cycle.
- Up step (en=1, up=1, count <= limit):
  - Compute sum = count + step in WIDTH+1 bits.
  - If sum <= limit: count = sum, state = UP, tc = 0.
  - If sum > limit and sat_mode=0 (wrap): count = 0, state = UP, tc = 1.
  - If sum > limit and sat_mode=1: count = limit, state = SAT_HI.
    - tc = 1 only on the cycle of entry into SAT_HI.
    - tc = 0 while already in SAT_HI and up=1 continues.
- Down step (en=1, up=0, count <= limit):
  - If step <= count: count = count - step, state = DOWN, tc = 0.
  - If step > count and sat_mode=0: count = limit, state = DOWN, tc = 1.
  - If step > count and sat_mode=1: count = 0, state = SAT_LO.
    - tc = 1 only on entry into SAT_LO.
- Exit from saturation:
  - Reversing direction from SAT_HI (up=0) or SAT_LO (up=1) applies a normal step and moves to DOWN or UP.
  - load and rst also exit.
- step=0 with en=1: count unchanged, tc=0, state = UP or DOWN per the up input. SAT states hold.
- Exact landing: reaching exactly limit (up) or exactly 0 (down) is not a boundary event, so tc=0.
- limit=0: count stays 0.
  - Wrap mode: tc=1 on every enabled cycle with step != 0.
  - Saturate mode: tc=1 once, on SAT entry.
- Changing sat_mode or limit mid-operation takes effect on the next enabled edge.
- Asserting rst mid-count forces the reset values on that edge, regardless of en, load or state.
- Latency: every input affects count, tc and state on the next rising edge.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, up=1 -> count=0, tc=0, state=0. Release rst, limit=9, step=1, sat_mode=0 -> count 1,2,...,9,0. tc=1 only on the edge 9->0.
- Down wrap: load_val=2, load=1, then en=1, up=0, step=3, limit=9, sat_mode=0 -> count=9, tc=1, state=2.
- Saturate high: limit=200, load 190, up=1, step=7, sat_mode=1 -> 197, then 200 with tc=1 and state=3, then 200 with tc=0 for the next cycles. Then up=0 -> 193, state=2.
- Saturate low: load 5, up=0, step=4, sat_mode=1 -> 1, then 0 with tc=1 and state=4, then hold at 0 with tc=0. en=0 -> state stays 4.
- Load clamp and priority:
  - load_val=250, limit=100, load=1, en=1 -> count=100, state=0, tc=0.
  - load=1 and rst=1 together -> count=0.
- Limit lowered: count=50, limit changed to 20, en=1, up=1 -> count=20, tc=0. Next step=1 -> count=0 (wrap mode) with tc=1.
